// File: rtl/autoscale_shifter.sv
// Normalizes a signed (x, y) pair so its leading one sits just below the sign bit, via a pipelined log-depth barrel shifter.
// Latency SHIFT_WIDTH+2 cycles; streaming only, no backpressure (dout_valid mirrors din_valid delayed).
module autoscale_shifter #(
  parameter int DIN_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = $clog2(DIN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIN_WIDTH-1:0]   din_x,
  input  logic [DIN_WIDTH-1:0]   din_y,
  input  logic [SHIFT_WIDTH-1:0] msb_index,
  input  logic                   din_valid,
  output logic [DOUT_WIDTH-1:0]  dout_x,
  output logic [DOUT_WIDTH-1:0]  dout_y,
  output logic [SHIFT_WIDTH-1:0] dout_shift,
  output logic                   dout_zero,
  output logic                   dout_valid
);

  localparam logic [SHIFT_WIDTH-1:0] MAX_IDX = SHIFT_WIDTH'(DIN_WIDTH - 2);

  // Per-stage views: index 0 is the input register, index k the output of barrel stage k.
  logic [DIN_WIDTH-1:0]   xs [SHIFT_WIDTH+1];
  logic [DIN_WIDTH-1:0]   ys [SHIFT_WIDTH+1];
  logic [SHIFT_WIDTH-1:0] ss [SHIFT_WIDTH+1];
  logic                   zs [SHIFT_WIDTH+1];
  logic                   vs [SHIFT_WIDTH+1];

  logic                   zero_in;
  logic [SHIFT_WIDTH-1:0] s_in;

  // Zero is taken from the data: the finder reports index 0 for both zero and bit-0 inputs.
  always_comb begin
    zero_in = (din_x == '0) && (din_y == '0);
    s_in    = '0;
    if (!zero_in && (msb_index <= MAX_IDX))
      s_in = MAX_IDX - msb_index;
  end

  logic [DIN_WIDTH-1:0]   x0_q, y0_q;
  logic [SHIFT_WIDTH-1:0] s0_q;
  logic                   z0_q, v0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0;
      y0_q <= '0;
      s0_q <= '0;
      z0_q <= 1'b0;
      v0_q <= 1'b0;
    end else begin
      x0_q <= din_x;
      y0_q <= din_y;
      s0_q <= s_in;
      z0_q <= zero_in;
      v0_q <= din_valid;
    end
  end

  assign xs[0] = x0_q;
  assign ys[0] = y0_q;
  assign ss[0] = s0_q;
  assign zs[0] = z0_q;
  assign vs[0] = v0_q;

  for (genvar k = 1; k <= SHIFT_WIDTH; k++) begin : g_barrel
    logic [DIN_WIDTH-1:0]   x_q, y_q;
    logic [SHIFT_WIDTH-1:0] s_q;
    logic                   z_q, v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        x_q <= '0;
        y_q <= '0;
        s_q <= '0;
        z_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        x_q <= ss[k-1][k-1] ? (xs[k-1] << (2 ** (k - 1))) : xs[k-1];
        y_q <= ss[k-1][k-1] ? (ys[k-1] << (2 ** (k - 1))) : ys[k-1];
        s_q <= ss[k-1];
        z_q <= zs[k-1];
        v_q <= vs[k-1];
      end
    end

    assign xs[k] = x_q;
    assign ys[k] = y_q;
    assign ss[k] = s_q;
    assign zs[k] = z_q;
    assign vs[k] = v_q;
  end

  // Keep the top DOUT_WIDTH bits; dropping the rest rounds toward negative infinity.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_x     <= '0;
      dout_y     <= '0;
      dout_shift <= '0;
      dout_zero  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_x     <= xs[SHIFT_WIDTH][DIN_WIDTH-1 -: DOUT_WIDTH];
      dout_y     <= ys[SHIFT_WIDTH][DIN_WIDTH-1 -: DOUT_WIDTH];
      dout_shift <= ss[SHIFT_WIDTH];
      dout_zero  <= zs[SHIFT_WIDTH];
      dout_valid <= vs[SHIFT_WIDTH];
    end
  end

  if (DOUT_WIDTH < DIN_WIDTH) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^{xs[SHIFT_WIDTH][DIN_WIDTH-DOUT_WIDTH-1:0],
                           ys[SHIFT_WIDTH][DIN_WIDTH-DOUT_WIDTH-1:0]};
  end

endmodule
